conv_window_gen: RTL and testbench

- Streaming K×K sliding-window generator feeding the convolution MAC array; successor to the fixed 5×5 line buffer.
- Accepts one multi-channel pixel per handshake in raster order. Emits a complete K×K×CHANNELS window for every valid output position.
- Supports parametrised kernel size, stride and channel count, valid/ready backpressure on both sides, end-of-frame marking and automatic back-to-back frames.

---
 rtl/conv_window_gen.sv | 163 ++++++++++++++++
 tb/tb_conv_window_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: K-1 delay-line row buffers feed a KxK shift
// window; a window is emitted for every stride-aligned position once K rows are present.
module conv_window_gen #(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int DATA_BITS   = 8,
    parameter int CHANNELS    = 1,
    parameter int FILTER_SIZE = 5,
    parameter int STRIDE      = 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [CHANNELS*DATA_BITS-1:0]                         data_in,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [FILTER_SIZE*FILTER_SIZE*CHANNELS*DATA_BITS-1:0] data_out,
    output logic                                                  out_last,
    output logic                                                  frame_done
);

    localparam int PIX   = CHANNELS * DATA_BITS;
    localparam int K     = FILTER_SIZE;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int OUT_W = (WIDTH - K) / STRIDE + 1;
    localparam int OUT_H = (HEIGHT - K) / STRIDE + 1;

    localparam logic [CW-1:0] COL_MAX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [CW-1:0] COL_PRE   = CW'(K - 2);
    localparam logic [CW-1:0] COL_LAST  = CW'(K - 1 + STRIDE * (OUT_W - 1));
    localparam logic [RW-1:0] ROW_MAX   = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [RW-1:0] ROW_PRE   = RW'(K - 2);
    localparam logic [RW-1:0] ROW_LAST  = RW'(K - 1 + STRIDE * (OUT_H - 1));
    localparam logic [SW-1:0] PH_MAX    = SW'(STRIDE - 1);

    generate
        if (K < 2 || K > WIDTH || K > HEIGHT || STRIDE < 1 || CHANNELS < 1 || DATA_BITS < 1) begin : g_bad_param
            $error("conv_window_gen: illegal parameter combination");
        end
    endgenerate

    logic [CW-1:0]          col_reg;
    logic [RW-1:0]          row_reg;
    logic [SW-1:0]          col_ph_reg;
    logic [SW-1:0]          row_ph_reg;
    logic                   out_valid_reg;
    logic                   out_last_reg;
    logic                   frame_done_reg;
    logic [K*K*PIX-1:0]     win_reg;

    logic                   accept;
    logic                   emit;
    logic                   col_wrap;
    logic                   row_wrap;
    logic [CW-1:0]          col_next;
    logic [RW-1:0]          row_next;
    logic [CW-1:0]          rd_addr;
    logic [(K-1)*PIX-1:0]   lb_rd;
    logic [K*PIX-1:0]       col_in;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_wrap = (col_reg == COL_MAX);
    assign row_wrap = (row_reg == ROW_MAX);
    assign col_next = col_wrap ? '0 : col_reg + 1'b1;
    assign row_next = !col_wrap ? row_reg : (row_wrap ? '0 : row_reg + 1'b1);
    assign emit     = accept && (row_reg >= ROW_FIRST) && (col_reg >= COL_FIRST)
                      && (row_ph_reg == '0) && (col_ph_reg == '0);

    // The RAM read port always points at the column the next accepted pixel will use,
    // so the registered read data is ready the moment that pixel arrives.
    assign rd_addr  = rst ? '0 : (accept ? col_next : col_reg);

    // Column entering the window: oldest buffered row in the low slice, live pixel on top.
    assign col_in   = {data_in, lb_rd};

    genvar gi;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_line
            logic [PIX-1:0] mem [WIDTH];
            logic [PIX-1:0] rd_reg;
            logic [PIX-1:0] wr_data;

            if (gi == K - 2) begin : g_newest
                assign wr_data = data_in;
            end else begin : g_older
                assign wr_data = lb_rd[(gi+1)*PIX +: PIX];
            end

            always_ff @(posedge clk) begin
                if (accept && !rst) begin
                    mem[col_reg] <= wr_data;
                end
                rd_reg <= mem[rd_addr];
            end

            assign lb_rd[gi*PIX +: PIX] = rd_reg;
        end
    endgenerate

    // Each row of the window shifts one element left; the new column lands at c = K-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_reg <= '0;
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_reg[(r*K+c)*PIX +: PIX] <= win_reg[(r*K+c+1)*PIX +: PIX];
                end
                win_reg[(r*K+K-1)*PIX +: PIX] <= col_in[r*PIX +: PIX];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg        <= '0;
            row_reg        <= '0;
            col_ph_reg     <= '0;
            row_ph_reg     <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= accept && col_wrap && row_wrap;
            if (accept) begin
                col_reg <= col_next;
                row_reg <= row_next;
                // Phases restart so the first full-window column/row is phase 0.
                if (col_reg == COL_PRE || col_ph_reg == PH_MAX) begin
                    col_ph_reg <= '0;
                end else begin
                    col_ph_reg <= col_ph_reg + 1'b1;
                end
                if (col_wrap) begin
                    if (row_reg == ROW_PRE || row_ph_reg == PH_MAX) begin
                        row_ph_reg <= '0;
                    end else begin
                        row_ph_reg <= row_ph_reg + 1'b1;
                    end
                end
            end
            if (emit) begin
                out_valid_reg <= 1'b1;
                out_last_reg  <= (row_reg == ROW_LAST) && (col_reg == COL_LAST);
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_last   = out_last_reg;
    assign frame_done = frame_done_reg;
    assign data_out   = win_reg;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: three instances cover 6x6/K3/S1, 7x7/K3/S2 and
// a 4x4/K2 two-channel configuration; windows are captured and compared to hand values.
module tb_conv_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Instance A: 6x6, K=3, stride 1
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_frame_done;
    logic [7:0]  a_data_in;
    logic [71:0] a_data_out;
    // Instance B: 7x7, K=3, stride 2
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_frame_done;
    logic [7:0]  b_data_in;
    logic [71:0] b_data_out;
    // Instance C: 4x4, K=2, two channels
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_frame_done;
    logic [15:0] c_data_in;
    logic [63:0] c_data_out;

    conv_window_gen #(.WIDTH(6), .HEIGHT(6), .DATA_BITS(8), .CHANNELS(1), .FILTER_SIZE(3), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out),
        .out_last(a_out_last), .frame_done(a_frame_done));

    conv_window_gen #(.WIDTH(7), .HEIGHT(7), .DATA_BITS(8), .CHANNELS(1), .FILTER_SIZE(3), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out),
        .out_last(b_out_last), .frame_done(b_frame_done));

    conv_window_gen #(.WIDTH(4), .HEIGHT(4), .DATA_BITS(8), .CHANNELS(2), .FILTER_SIZE(2), .STRIDE(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .data_in(c_data_in),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .data_out(c_data_out),
        .out_last(c_out_last), .frame_done(c_frame_done));

    logic [71:0] a_win_q [$];
    logic        a_last_q [$];
    logic [71:0] b_win_q [$];
    logic        b_last_q [$];
    logic [63:0] c_win_q [$];
    logic        c_last_q [$];
    int          a_fd = 0;
    int          b_fd = 0;
    int          c_fd = 0;

    // Record every completed output transfer and frame_done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_out_valid && a_out_ready) begin
                a_win_q.push_back(a_data_out);
                a_last_q.push_back(a_out_last);
            end
            if (b_out_valid && b_out_ready) begin
                b_win_q.push_back(b_data_out);
                b_last_q.push_back(b_out_last);
            end
            if (c_out_valid && c_out_ready) begin
                c_win_q.push_back(c_data_out);
                c_last_q.push_back(c_out_last);
            end
            if (a_frame_done) a_fd++;
            if (b_frame_done) b_fd++;
            if (c_frame_done) c_fd++;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Window whose bottom-right pixel is (r,c); pixel value = base + row*w + col, channel ch adds 64*ch.
    function automatic logic [127:0] exp_win(input int w, input int k, input int chans,
                                             input int base, input int r, input int c);
        logic [127:0] v;
        int s;
        v = '0;
        for (int rr = 0; rr < k; rr++) begin
            for (int cc = 0; cc < k; cc++) begin
                for (int ch = 0; ch < chans; ch++) begin
                    s = base + (r - k + 1 + rr) * w + (c - k + 1 + cc) + ch * 64;
                    v[((rr*k+cc)*chans+ch)*8 +: 8] = s[7:0];
                end
            end
        end
        return v;
    endfunction

    task automatic push(input int which, input int v);
        bit got;
        got = 1'b0;
        case (which)
            0:       begin a_in_valid = 1'b1; a_data_in = 8'(v); end
            1:       begin b_in_valid = 1'b1; b_data_in = 8'(v); end
            default: begin c_in_valid = 1'b1; c_data_in = {8'(v + 64), 8'(v)}; end
        endcase
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            case (which)
                0:       got = a_in_ready;
                1:       got = b_in_ready;
                default: got = c_in_ready;
            endcase
        end
        if (!got) check($sformatf("push%0d_ready_timeout", which), 128'(got), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic verify_a(input string tag, input int start, input int fd0, input int nfr);
        int i;
        i = start;
        check({tag, "_count"}, 128'(a_win_q.size() - start), 128'(16 * nfr));
        check({tag, "_frame_done_count"}, 128'(a_fd - fd0), 128'(nfr));
        for (int f = 0; f < nfr; f++) begin
            for (int r = 2; r < 6; r++) begin
                for (int c = 2; c < 6; c++) begin
                    if (i < a_win_q.size()) begin
                        check($sformatf("%s_win%0d", tag, i - start), 128'(a_win_q[i]), exp_win(6, 3, 1, 100 * f, r, c));
                        check($sformatf("%s_last%0d", tag, i - start), 128'(a_last_q[i]), 128'(r == 5 && c == 5));
                    end
                    i++;
                end
            end
        end
    endtask

    initial begin
        int st;
        int fd0;
        logic [71:0] hold;

        rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_data_in = '0; b_data_in = '0; c_data_in = '0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_in_ready", 128'(a_in_ready), 128'(1));
        check("rst_out_last", 128'(a_out_last), 128'(0));
        check("rst_frame_done", 128'(a_frame_done), 128'(0));
        check("rst_data_out", 128'(a_data_out), 128'(0));
        check("rst_b_out_valid", 128'(b_out_valid), 128'(0));

        // Test 1: 6x6, K=3, stride 1, continuous
        st = a_win_q.size(); fd0 = a_fd;
        for (int p = 0; p < 36; p++) begin
            push(0, p);
            if (p == 13) check("t1_no_win_at_13", 128'(a_out_valid), 128'(0));
            if (p == 14) begin
                check("t1_first_valid", 128'(a_out_valid), 128'(1));
                check("t1_first_data", 128'(a_data_out), exp_win(6, 3, 1, 0, 2, 2));
            end
            if (p == 35) begin
                check("t1_frame_done", 128'(a_frame_done), 128'(1));
                check("t1_out_last", 128'(a_out_last), 128'(1));
                check("t1_last_data", 128'(a_data_out), exp_win(6, 3, 1, 0, 5, 5));
            end
        end
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t1_frame_done_pulse", 128'(a_frame_done), 128'(0));
        check("t1_idle_valid", 128'(a_out_valid), 128'(0));
        verify_a("t1", st, fd0, 1);

        // Test 3: backpressure for 5 cycles after pixel 20
        st = a_win_q.size(); fd0 = a_fd;
        for (int p = 0; p < 36; p++) begin
            push(0, p);
            if (p == 20) begin
                a_out_ready = 1'b0;
                a_in_valid  = 1'b0;
                hold = a_data_out;
                check("t3_stall_valid", 128'(a_out_valid), 128'(1));
                check("t3_stall_data", 128'(hold), exp_win(6, 3, 1, 0, 3, 2));
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check($sformatf("t3_in_ready_%0d", s), 128'(a_in_ready), 128'(0));
                    check($sformatf("t3_hold_%0d", s), 128'(a_data_out), 128'(hold));
                    check($sformatf("t3_valid_%0d", s), 128'(a_out_valid), 128'(1));
                end
                @(posedge clk);
                #1;
                a_out_ready = 1'b1;
            end
        end
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        verify_a("t3", st, fd0, 1);

        // Test 4: two frames back to back, second frame offset by 100
        st = a_win_q.size(); fd0 = a_fd;
        for (int p = 0; p < 72; p++) begin
            push(0, (p < 36) ? p : 100 + p - 36);
        end
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        verify_a("t4", st, fd0, 2);

        // Test 5: reset after pixel 20, then a clean frame
        for (int p = 0; p < 21; p++) push(0, p);
        a_in_valid = 1'b0;
        check("t5_pre_rst_valid", 128'(a_out_valid), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_post_rst_valid", 128'(a_out_valid), 128'(0));
        check("t5_post_rst_data", 128'(a_data_out), 128'(0));
        check("t5_post_rst_in_ready", 128'(a_in_ready), 128'(1));
        st = a_win_q.size(); fd0 = a_fd;
        for (int p = 0; p < 36; p++) push(0, p);
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        verify_a("t5", st, fd0, 1);

        // Test 2: 7x7, K=3, stride 2
        st = b_win_q.size(); fd0 = b_fd;
        for (int p = 0; p < 49; p++) begin
            push(1, p);
            if (p == 16) begin
                check("t2_first_valid", 128'(b_out_valid), 128'(1));
                check("t2_first_data", 128'(b_data_out), exp_win(7, 3, 1, 0, 2, 2));
            end
            if (p == 17) check("t2_no_win_at_17", 128'(b_out_valid), 128'(0));
        end
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t2_count", 128'(b_win_q.size() - st), 128'(9));
        check("t2_frame_done_count", 128'(b_fd - fd0), 128'(1));
        for (int i = 0; i < 9 && st + i < b_win_q.size(); i++) begin
            check($sformatf("t2_win%0d", i), 128'(b_win_q[st+i]), exp_win(7, 3, 1, 0, 2 + 2 * (i / 3), 2 + 2 * (i % 3)));
            check($sformatf("t2_last%0d", i), 128'(b_last_q[st+i]), 128'(i == 8));
        end

        // Test 6: two channels, K=2, 4x4
        st = c_win_q.size();
        for (int p = 0; p < 16; p++) begin
            push(2, p);
            if (p == 4) check("t6_no_win_at_4", 128'(c_out_valid), 128'(0));
            if (p == 5) begin
                check("t6_first_valid", 128'(c_out_valid), 128'(1));
                check("t6_first_data", 128'(c_data_out), exp_win(4, 2, 2, 0, 1, 1));
            end
        end
        c_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_count", 128'(c_win_q.size() - st), 128'(9));
        if (c_win_q.size() == st + 9) begin
            check("t6_last_data", 128'(c_win_q[st+8]), exp_win(4, 2, 2, 0, 3, 3));
            check("t6_last_flag", 128'(c_last_q[st+8]), 128'(1));
            check("t6_mid_flag", 128'(c_last_q[st+7]), 128'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
